// File: rtl/display_pkg.sv
// Shared types and sizing for the display source scheduler slice.
package display_pkg;

    localparam int unsigned NYBBLES     = 4;
    localparam int unsigned DATA_WIDTH  = 4 * NYBBLES;
    localparam int unsigned MAX_SOURCES = 8;
    localparam int unsigned IDX_W       = $clog2(MAX_SOURCES);

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        GAP
    } state_t;

endpackage

// File: rtl/round_robin_picker.sv
// Combinational round-robin pick: first set candidate at or after start_index, wrapping.
module round_robin_picker
    import display_pkg::*;
#(
    parameter int unsigned number_of_sources = 4
) (
    input  logic [number_of_sources-1:0] candidates,
    input  logic [IDX_W-1:0]             start_index,
    output logic [number_of_sources-1:0] pick,
    output logic [IDX_W-1:0]             pick_index,
    output logic                         valid
);

    int unsigned best_distance;
    int unsigned best_position;
    int unsigned distance;

    // Rank each position by its circular distance from the start; the nearest candidate wins.
    always_comb begin
        best_distance = number_of_sources;
        best_position = 0;
        distance      = 0;
        pick          = '0;
        for (int unsigned j = 0; j < number_of_sources; j++) begin
            if (j >= 32'(start_index)) distance = j - 32'(start_index);
            else                       distance = j + number_of_sources - 32'(start_index);
            if (candidates[j] && distance < best_distance) begin
                best_distance = distance;
                best_position = j;
            end
        end
        valid      = best_distance < number_of_sources;
        pick_index = IDX_W'(best_position);
        for (int unsigned j = 0; j < number_of_sources; j++) begin
            pick[j] = valid && (best_position == j);
        end
    end

endmodule

// File: rtl/display_source_scheduler.sv
// Time-shares one segmented display between requesters: round-robin with urgent override,
// fixed dwell per grant and a blanking gap between grants.
module display_source_scheduler
    import display_pkg::*;
#(
    parameter int unsigned number_of_sources = 4,
    parameter int unsigned number_of_nybbles = 4,
    parameter int unsigned dwell_cycles      = 2**24,
    parameter int unsigned gap_cycles        = 2**10
) (
    input  logic                                             clock,
    input  logic                                             reset_n,
    input  logic [number_of_sources-1:0]                     request,
    input  logic [number_of_sources-1:0]                     urgent,
    input  logic [number_of_sources*4*number_of_nybbles-1:0] source_data,
    output logic [number_of_sources-1:0]                     grant,
    output logic [4*number_of_nybbles-1:0]                   data,
    output logic                                             blank,
    output logic [IDX_W-1:0]                                 active_index,
    output logic                                             slot_done,
    output logic                                             idle
);

    localparam int unsigned N   = number_of_sources;
    localparam int unsigned DW  = 4 * number_of_nybbles;
    localparam int unsigned DCW = $clog2(dwell_cycles);
    localparam int unsigned GCW = (gap_cycles == 0) ? 1 : $clog2(gap_cycles + 1);
    localparam logic [DCW-1:0] DWELL_LAST = DCW'(dwell_cycles - 1);
    localparam logic [GCW-1:0] GAP_LAST   = GCW'((gap_cycles == 0) ? 0 : gap_cycles - 1);

    state_t           state, state_nx;
    logic [IDX_W-1:0] owner, owner_nx;
    logic [IDX_W-1:0] pointer, pointer_nx;
    logic [DCW-1:0]   dwell_count, dwell_nx;
    logic [GCW-1:0]   gap_count, gap_nx;

    logic [N-1:0]     owner_onehot;
    logic [N-1:0]     others_request;
    logic [N-1:0]     candidates;
    logic [N-1:0]     pick_onehot;
    logic [IDX_W-1:0] pick_index;
    logic             pick_valid;
    logic [DW-1:0]    owner_data;
    logic             owner_request, owner_urgent, preempt, dwell_end;
    logic             leave_show, take_pick;

    always_comb begin
        owner_onehot = '0;
        owner_data   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            owner_onehot[i] = (owner == IDX_W'(i));
            if (owner == IDX_W'(i)) owner_data = source_data[i*DW +: DW];
        end
    end

    assign owner_request  = |(request & owner_onehot);
    assign owner_urgent   = |(urgent & owner_onehot);
    assign others_request = request & ~owner_onehot;
    assign preempt        = (|(others_request & urgent)) && !owner_urgent;
    assign candidates     = (|(request & urgent)) ? (request & urgent) : request;
    assign dwell_end      = (dwell_count == DWELL_LAST);

    round_robin_picker #(
        .number_of_sources(N)
    ) picker (
        .candidates (candidates),
        .start_index(pointer),
        .pick       (pick_onehot),
        .pick_index (pick_index),
        .valid      (pick_valid)
    );

    always_comb begin
        state_nx   = state;
        owner_nx   = owner;
        pointer_nx = pointer;
        dwell_nx   = dwell_count;
        gap_nx     = gap_count;
        leave_show = 1'b0;
        take_pick  = 1'b0;
        case (state)
            IDLE: take_pick = 1'b1;
            SHOW: begin
                if (dwell_end) begin
                    if (others_request == '0 && owner_request) dwell_nx = '0;
                    else                                       leave_show = 1'b1;
                end else if (!owner_request || preempt) begin
                    leave_show = 1'b1;
                end else begin
                    dwell_nx = dwell_count + DCW'(1);
                end
            end
            GAP: begin
                if (gap_count == GAP_LAST) take_pick = 1'b1;
                else                       gap_nx = gap_count + GCW'(1);
            end
            default: state_nx = IDLE;
        endcase
        // Without a gap, leaving SHOW arbitrates on the same edge instead of visiting GAP.
        if (leave_show) begin
            if (gap_cycles == 0) begin
                take_pick = 1'b1;
            end else begin
                state_nx = GAP;
                gap_nx   = '0;
            end
        end
        if (take_pick) begin
            if (pick_valid) begin
                state_nx   = SHOW;
                owner_nx   = pick_index;
                pointer_nx = (pick_index == IDX_W'(N - 1)) ? '0 : pick_index + IDX_W'(1);
                dwell_nx   = '0;
            end else begin
                state_nx = IDLE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= IDLE;
            owner       <= '0;
            pointer     <= '0;
            dwell_count <= '0;
            gap_count   <= '0;
            data        <= '0;
        end else begin
            state       <= state_nx;
            owner       <= owner_nx;
            pointer     <= pointer_nx;
            dwell_count <= dwell_nx;
            gap_count   <= gap_nx;
            if (state == SHOW) data <= owner_data;
        end
    end

    assign grant        = (state == SHOW) ? owner_onehot : '0;
    assign blank        = (state != SHOW);
    assign active_index = owner;
    assign slot_done    = (state == SHOW) && dwell_end;
    assign idle         = (state == IDLE);

endmodule

// File: doc/display_source_scheduler.md
# display_source_scheduler

Time-shares one 4-digit segmented display driver between several requesters: on-board counters, status words and debug values. Arbitration is round-robin with an urgent override. Each grant holds for a fixed dwell, and a blanking gap separates grants so the display never ghosts between sources. The block sits between the requesting logic and `segmented_display_driver`. Its `data` output feeds the driver's `data` input, and `blank` gates the driver's anode enables.

## Interface
Parameters:
- `number_of_sources`, 4: number of requesters, legal 2..8.
- `number_of_nybbles`, 4: digits on the display; data width is 4×this.
- `dwell_cycles`, 2**24: clocks per display slot, ≥2.
- `gap_cycles`, 2**10: blank clocks between slots, ≥0; 0 removes the gap.

Ports:
- `clock`  in  1  the single clock; every flop is on its rising edge.
- `reset_n`  in  1  reset; synchronous and active-low.
- `request`  in  N  per-source request for display time.
- `urgent`  in  N  per-source priority flag; ignored unless that source's `request` is also high.
- `source_data`  in  N×16  flattened source values; source i occupies bits [16i+15:16i].
- `grant`  out  N  one-hot owner of the display; all-zero when nobody owns it.
- `data`  out  16  registered copy of the granted source's value, to the driver.
- `blank`  out  1  high means the driver's anodes must be off.
- `active_index`  out  3  index of the current or most recent owner.
- `slot_done`  out  1  one-cycle pulse at the end of every completed dwell.
- `idle`  out  1  high in the IDLE state.

## Operation
- **States:** IDLE, SHOW, GAP.
- **Reset values:** state IDLE, `grant`=0, `data`=16'h0000, `blank`=1, `active_index`=0, `slot_done`=0, `idle`=1. The round-robin pointer resets so that source 0 is searched first.
- **Arbitration:**
  - Evaluated in IDLE, at the end of GAP, and at the end of a dwell.
  - The candidate set is the urgent requesters if any exist; otherwise it is all requesters.
  - Search starts at (last granted + 1) mod N and picks the first candidate found.
- **IDLE:** on any `request`, arbitrate and enter SHOW. Otherwise stay in IDLE.
- **SHOW:**
  - Outputs: `grant` one-hot, `blank`=0, `active_index`=owner.
  - Each clock, `data` ← the owner's slice of `source_data`.
  - The dwell counter counts from 0 to `dwell_cycles`−1.
- **End of dwell:**
  - `slot_done` pulses.
  - If another source is requesting, go to GAP.
  - If only the owner is requesting, re-grant the owner with no gap and restart the counter.
  - If nobody is requesting, go to GAP.
- **Early exit to GAP, without a `slot_done` pulse:**
  - The owner drops `request`.
  - Urgent preemption: a non-owner has urgent and request high while the owner is not urgent.
- **GAP:**
  - Outputs: `grant`=0, `blank`=1; `data` holds its last value.
  - Lasts `gap_cycles` clocks, then arbitrates into SHOW, or into IDLE if nobody is requesting.
  - With `gap_cycles`=0, every SHOW→GAP transition instead arbitrates directly into SHOW or IDLE on the same edge.
- **Arithmetic:** the dwell counter is $clog2(dwell_cycles) bits wide and the gap counter is $clog2(gap_cycles+1) bits wide. Counters never wrap; each is cleared when its state is entered.

## Timing
- **Request to grant:** a request sampled in IDLE at edge k gives `grant`, `blank`=0 and `idle`=0 valid after edge k.
- **Data latency:** `data` reflects `source_data` sampled at the previous edge (1-cycle latency). It first becomes valid after edge k+1.
- **Slot length:** the last dwell cycle is the clock that starts `dwell_cycles`−1 edges after grant. `slot_done` is high during exactly that clock. The state change occurs on the following edge.
- **Request and urgent changes:** a drop of `request` or a preempting `urgent` sampled at edge m causes `grant`=0 and `blank`=1 after edge m.
- **Reset:** `reset_n` low at any edge, including mid-SHOW or mid-GAP, forces all reset values after that edge. It takes priority over every other event.
- **Simultaneous events:** if the owner drops `request` on the same edge as the end of dwell, the slot counts as completed, so `slot_done` pulses. The block then goes to GAP.

## Structure
- **Shared package `display_pkg`:** the state enum (IDLE/SHOW/GAP), DATA_WIDTH = 4×`number_of_nybbles`, and MAX_SOURCES = 8.
- **Sub-module `round_robin_picker`:** a combinational block. Inputs are the candidate mask and the start index. Outputs are the one-hot pick, the encoded index and a valid flag.
- Everything else (FSM, counters, data register) lives in `display_source_scheduler`.

## Test plan
- **Reset and first grant:** reset with `request`=0, then set `request`=4'b0100 with source 2 data 16'h1234. Expect `grant`=0100 one edge later, `data`=16'h1234 one edge after that, `blank`=0 and `active_index`=2.
- **Round-robin rotation:** hold `request`=4'b1111 with `dwell_cycles`=8 and `gap_cycles`=2. Expect the grant order 0,1,2,3,0. Each slot lasts 8 clocks with one `slot_done` pulse, and exactly 2 clocks of `blank`=1 with `grant`=0 separate slots.
- **Sole requester:** only source 1 requests. Expect back-to-back regrants of source 1 with no gap, `slot_done` every 8 clocks, and `blank` staying 0.
- **Urgent preemption:** during source 0's slot, assert `request`[3] and `urgent`[3] at cycle 3. Expect `grant`=0 after that edge and no `slot_done`. After the gap, expect `grant`=1000.
- **Mid-operation reset and boundary cases:**
  - Pulse `reset_n` low in the middle of a GAP. Expect every output at its reset value and the next grant going to source 0.
  - With `gap_cycles`=0 and owner 0 dropping `request` while source 1 requests, expect the grant to go directly from 0001 to 0010 on one edge.
